// File: rtl/osd_hex_overlay_multi_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : osd_hex_overlay_multi_if                                        |
// | Brief    : Video/debug bundle between a video source and the hex OSD.      |
// |            master = source/sink side, slave = overlay block.               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface osd_hex_overlay_multi_if #(
  parameter int NUM_BYTES = 4
);
  logic                   pixel_ce;
  logic                   enable;
  logic [8*NUM_BYTES-1:0] debug_value;
  logic [7:0]             RGB_in_R;
  logic [7:0]             RGB_in_G;
  logic [7:0]             RGB_in_B;
  logic                   HS;
  logic                   VS;
  logic                   HBLANK;
  logic                   VBLANK;
  logic [7:0]             RGB_out_R;
  logic [7:0]             RGB_out_G;
  logic [7:0]             RGB_out_B;
  logic                   HS_out;
  logic                   VS_out;
  logic                   HBLANK_out;
  logic                   VBLANK_out;

  modport master (
    output pixel_ce, enable, debug_value,
    output RGB_in_R, RGB_in_G, RGB_in_B, HS, VS, HBLANK, VBLANK,
    input  RGB_out_R, RGB_out_G, RGB_out_B, HS_out, VS_out, HBLANK_out, VBLANK_out
  );

  modport slave (
    input  pixel_ce, enable, debug_value,
    input  RGB_in_R, RGB_in_G, RGB_in_B, HS, VS, HBLANK, VBLANK,
    output RGB_out_R, RGB_out_G, RGB_out_B, HS_out, VS_out, HBLANK_out, VBLANK_out
  );
endinterface
`default_nettype wire

// File: rtl/osd_hex_overlay_multi.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : osd_hex_overlay_multi                                           |
// | Brief    : Debug OSD drawing NUM_BYTES of a debug bus as hex digits in a   |
// |            scalable box over the video stream. Own H/V counters, frame-    |
// |            coherent snapshot, 8x8 font ROM, 3-stage pixel_ce pipeline.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module osd_hex_overlay_multi #(
  parameter int          NUM_BYTES  = 4,
  parameter int          X0         = 16,
  parameter int          Y0         = 16,
  parameter int          SCALE_LOG2 = 0,
  parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB     = 24'h000000,
  parameter bit          BG_EN      = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  osd_hex_overlay_multi_if.slave  bus
);

  localparam int          c_DIGITS  = 2 * NUM_BYTES;
  localparam int          c_BOX_W   = (16 * NUM_BYTES) << SCALE_LOG2;
  localparam int          c_BOX_H   = 8 << SCALE_LOG2;
  localparam logic [10:0] c_POS_MAX = 11'd2047;

  // position counters and frame snapshot
  logic [10:0]            r_hpos;
  logic [10:0]            r_vpos;
  logic                   r_hblank_prev;
  logic                   r_vblank_prev;
  logic [8*NUM_BYTES-1:0] r_snap;
  logic                   r_en_latched;

  // pipeline stages
  logic        r1_in_box, r2_in_box;
  logic [3:0]  r1_nibble;
  logic [2:0]  r1_row;
  logic [2:0]  r1_col, r2_col;
  logic [7:0]  r2_bits;
  logic [23:0] r1_rgb, r2_rgb, r3_rgb;
  logic [3:0]  r1_sync, r2_sync, r3_sync;   // {HS, VS, HBLANK, VBLANK}

  logic        w_hb_rise;
  logic        w_vb_rise;
  logic [31:0] w_hx, w_vy;
  logic        w_in_box;
  logic [10:0] w_hrel, w_vrel, w_dx;
  logic [7:0]  w_digit;
  logic [2:0]  w_col, w_row;
  logic [3:0]  w_nibble;
  logic        w_bit;

  assign w_hb_rise = bus.HBLANK & ~r_hblank_prev;
  assign w_vb_rise = bus.VBLANK & ~r_vblank_prev;

  // Box test done in 32 bits so a box reaching past the counter range clips instead of wrapping
  assign w_hx     = {21'd0, r_hpos};
  assign w_vy     = {21'd0, r_vpos};
  assign w_in_box = !bus.HBLANK && !bus.VBLANK &&
                    (w_hx >= 32'(X0)) && (w_hx < 32'(X0 + c_BOX_W)) &&
                    (w_vy >= 32'(Y0)) && (w_vy < 32'(Y0 + c_BOX_H));

  assign w_hrel  = r_hpos - 11'(X0);
  assign w_vrel  = r_vpos - 11'(Y0);
  assign w_dx    = w_hrel >> SCALE_LOG2;
  assign w_digit = w_dx[10:3];
  assign w_col   = w_dx[2:0];
  assign w_row   = 3'(w_vrel >> SCALE_LOG2);

  // 8x8 hex glyphs, row 0 in the top byte, bit 7 is the leftmost column
  function automatic logic [7:0] glyph_row(input logic [3:0] nib, input logic [2:0] row);
    logic [63:0] g;
    case (nib)
      4'h0: g = 64'h3C666E7666663C00;
      4'h1: g = 64'h183818181818_7E00;
      4'h2: g = 64'h3C66060C30607E00;
      4'h3: g = 64'h3C66061C06663C00;
      4'h4: g = 64'h0C1C3C6C7E0C0C00;
      4'h5: g = 64'h7E607C0606663C00;
      4'h6: g = 64'h3C607C6666663C00;
      4'h7: g = 64'h7E060C1830303000;
      4'h8: g = 64'h3C66663C66663C00;
      4'h9: g = 64'h3C66663E060C3800;
      4'hA: g = 64'h183C66667E666600;
      4'hB: g = 64'h7C66667C66667C00;
      4'hC: g = 64'h3C66606060663C00;
      4'hD: g = 64'h786C6666666C7800;
      4'hE: g = 64'h7E60607C60607E00;
      default: g = 64'h7E60607C60606000;
    endcase
    g = g << {row, 3'b000};
    return g[63:56];
  endfunction

  // pick the snapshot nibble for the current digit, most significant digit leftmost
  always_comb begin
    w_nibble = 4'h0;
    for (int i = 0; i < c_DIGITS; i++) begin
      if (w_digit == 8'(i)) w_nibble = r_snap[(c_DIGITS-1-i)*4 +: 4];
    end
  end

  assign w_bit = r2_bits[3'd7 - r2_col];

  // pixel position counters and per-frame snapshot of value and enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hpos        <= 11'd0;
      r_vpos        <= 11'd0;
      r_hblank_prev <= 1'b0;
      r_vblank_prev <= 1'b0;
      r_snap        <= '0;
      r_en_latched  <= 1'b0;
    end else if (bus.pixel_ce) begin
      r_hblank_prev <= bus.HBLANK;
      r_vblank_prev <= bus.VBLANK;
      if (bus.HBLANK)               r_hpos <= 11'd0;
      else if (r_hpos != c_POS_MAX) r_hpos <= r_hpos + 11'd1;
      if (bus.VBLANK)                            r_vpos <= 11'd0;
      else if (w_hb_rise && r_vpos != c_POS_MAX) r_vpos <= r_vpos + 11'd1;
      if (w_vb_rise) begin
        r_snap       <= bus.debug_value;
        r_en_latched <= bus.enable;
      end
    end
  end

  // three-stage overlay pipeline: address capture, font read, output mux
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_in_box <= 1'b0;
      r1_nibble <= 4'h0;
      r1_row    <= 3'd0;
      r1_col    <= 3'd0;
      r1_rgb    <= 24'h0;
      r1_sync   <= 4'h0;
      r2_in_box <= 1'b0;
      r2_col    <= 3'd0;
      r2_bits   <= 8'h0;
      r2_rgb    <= 24'h0;
      r2_sync   <= 4'h0;
      r3_rgb    <= 24'h0;
      r3_sync   <= 4'h0;
    end else if (bus.pixel_ce) begin
      r1_in_box <= w_in_box & r_en_latched;
      r1_nibble <= w_nibble;
      r1_row    <= w_row;
      r1_col    <= w_col;
      r1_rgb    <= {bus.RGB_in_R, bus.RGB_in_G, bus.RGB_in_B};
      r1_sync   <= {bus.HS, bus.VS, bus.HBLANK, bus.VBLANK};
      r2_in_box <= r1_in_box;
      r2_col    <= r1_col;
      r2_bits   <= glyph_row(r1_nibble, r1_row);
      r2_rgb    <= r1_rgb;
      r2_sync   <= r1_sync;
      if (!r2_in_box)  r3_rgb <= r2_rgb;
      else if (w_bit)  r3_rgb <= FG_RGB;
      else if (BG_EN)  r3_rgb <= BG_RGB;
      else             r3_rgb <= r2_rgb;
      r3_sync   <= r2_sync;
    end
  end

  assign bus.RGB_out_R  = r3_rgb[23:16];
  assign bus.RGB_out_G  = r3_rgb[15:8];
  assign bus.RGB_out_B  = r3_rgb[7:0];
  assign bus.HS_out     = r3_sync[3];
  assign bus.VS_out     = r3_sync[2];
  assign bus.HBLANK_out = r3_sync[1];
  assign bus.VBLANK_out = r3_sync[0];

endmodule
`default_nettype wire

// File: tb/tb_osd_hex_overlay_multi.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_osd_hex_overlay_multi                                        |
// | Brief    : Directed bench for osd_hex_overlay_multi; four instances with   |
// |            different placement/scale/background share one video stream.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_osd_hex_overlay_multi;

  localparam int          c_VB    = 2;              // vblank lines at frame start
  localparam int          c_HB    = 8;              // hblank pixels at line end
  localparam int          c_LINES = c_VB + 34;
  localparam logic [23:0] c_VID   = 24'h102030;
  localparam logic [23:0] c_FG    = 24'hFFFFFF;
  localparam logic [23:0] c_BG    = 24'h000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, en, hb, vb, hs, vs;
  logic [15:0] dbg;
  int          width, ce_div;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  osd_hex_overlay_multi_if #(.NUM_BYTES(2)) vif [4] ();
  logic [23:0] out_rgb  [4];
  logic [3:0]  out_sync [4];

  for (genvar g = 0; g < 4; g++) begin : g_bus
    assign vif[g].pixel_ce    = ce;
    assign vif[g].enable      = en;
    assign vif[g].debug_value = dbg;
    assign vif[g].RGB_in_R    = c_VID[23:16];
    assign vif[g].RGB_in_G    = c_VID[15:8];
    assign vif[g].RGB_in_B    = c_VID[7:0];
    assign vif[g].HS          = hs;
    assign vif[g].VS          = vs;
    assign vif[g].HBLANK      = hb;
    assign vif[g].VBLANK      = vb;
    assign out_rgb[g]  = {vif[g].RGB_out_R, vif[g].RGB_out_G, vif[g].RGB_out_B};
    assign out_sync[g] = {vif[g].HS_out, vif[g].VS_out, vif[g].HBLANK_out, vif[g].VBLANK_out};
  end

  osd_hex_overlay_multi #(.NUM_BYTES(2), .X0(16), .Y0(16), .SCALE_LOG2(0),
    .FG_RGB(c_FG), .BG_RGB(c_BG), .BG_EN(1'b1)) u_dut0 (.clk(clk), .reset(rst), .bus(vif[0]));
  osd_hex_overlay_multi #(.NUM_BYTES(2), .X0(16), .Y0(16), .SCALE_LOG2(1),
    .FG_RGB(c_FG), .BG_RGB(c_BG), .BG_EN(1'b1)) u_dut1 (.clk(clk), .reset(rst), .bus(vif[1]));
  osd_hex_overlay_multi #(.NUM_BYTES(2), .X0(16), .Y0(16), .SCALE_LOG2(0),
    .FG_RGB(c_FG), .BG_RGB(c_BG), .BG_EN(1'b0)) u_dut2 (.clk(clk), .reset(rst), .bus(vif[2]));
  osd_hex_overlay_multi #(.NUM_BYTES(2), .X0(630), .Y0(16), .SCALE_LOG2(0),
    .FG_RGB(c_FG), .BG_RGB(c_BG), .BG_EN(1'b1)) u_dut3 (.clk(clk), .reset(rst), .bus(vif[3]));

  // captured output image per instance, indexed by the input pixel it belongs to
  logic [23:0] cap   [4][c_LINES][648];
  logic [3:0]  cap_s [c_LINES][648];
  int          q_ln [3];
  int          q_px [3];
  bit          q_v  [3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_px(input string tag, input int k, input int ln, input int px, input logic [23:0] e);
    check_eq($sformatf("%s_d%0d_l%0d_p%0d", tag, k, ln, px), {8'h0, cap[k][ln][px]}, {8'h0, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic record();
    if (q_v[2]) begin
      for (int k = 0; k < 4; k++) cap[k][q_ln[2]][q_px[2]] = out_rgb[k];
      cap_s[q_ln[2]][q_px[2]] = out_sync[0];
    end
  endtask

  // one pixel: a single pixel_ce pulse followed by ce_div-1 held cycles
  task automatic pix(input int ln, input int px);
    hb = (px >= width);
    vb = (ln < c_VB);
    hs = (px >= width + 2) && (px < width + 6);
    vs = (ln == 0);
    ce = 1'b1;
    tick();
    for (int i = 2; i > 0; i--) begin
      q_v[i] = q_v[i-1]; q_ln[i] = q_ln[i-1]; q_px[i] = q_px[i-1];
    end
    q_v[0] = 1'b1; q_ln[0] = ln; q_px[0] = px;
    record();
    for (int i = 1; i < ce_div; i++) begin
      ce = 1'b0;
      tick();
      record();
    end
  endtask

  task automatic frame(input int l0, input int l1);
    for (int ln = l0; ln < l1; ln++)
      for (int px = 0; px < width + c_HB; px++) pix(ln, px);
  endtask

  // row 0 of "1A2F" at X0=16: glyph rows 18,18,3C,7E, leftmost pixel is the MSB
  task automatic check_row0_1a2f(input string tag, input int k, input int ln);
    logic [31:0] m;
    logic [23:0] e;
    m = 32'h18183C7E;
    for (int px = 15; px <= 48; px++) begin
      if (px < 16 || px > 47) e = c_VID;
      else                    e = m[47-px] ? c_FG : c_BG;
      chk_px(tag, k, ln, px, e);
    end
  endtask

  initial begin
    ce = 1'b0; en = 1'b1; dbg = 16'h1A2F;
    hb = 1'b0; vb = 1'b0; hs = 1'b0; vs = 1'b0;
    width = 96; ce_div = 1;
    for (int i = 0; i < 3; i++) q_v[i] = 1'b0;

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("reset_d%0d", k), {4'h0, out_sync[k], out_rgb[k]}, 32'h0);
    rst = 1'b0;

    // frame 0: reset asserted mid-line, rest of frame is passthrough
    frame(0, c_VB + 5);
    for (int px = 0; px < 10; px++) pix(c_VB + 5, px);
    check_eq("pre_reset_rgb", {8'h0, out_rgb[0]}, {8'h0, c_VID});
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("async_reset_d%0d", k), {4'h0, out_sync[k], out_rgb[k]}, 32'h0);
    for (int i = 0; i < 3; i++) q_v[i] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int px = 10; px < width + c_HB; px++) pix(c_VB + 5, px);
    frame(c_VB + 6, c_LINES);
    chk_px("f0_pass", 0, c_VB + 16, 19, c_VID);
    chk_px("f0_pass", 0, c_VB + 16, 16, c_VID);
    chk_px("f0_pass", 0, c_VB + 21, 19, c_VID);
    chk_px("f0_pass", 1, c_VB + 17, 22, c_VID);

    // frame 1: overlay of 1A2F; debug changes to 0000 inside the box
    frame(0, c_VB + 18);
    dbg = 16'h0000;
    frame(c_VB + 18, c_LINES);
    check_row0_1a2f("f1_row0", 0, c_VB + 16);
    chk_px("f1_above", 0, c_VB + 15, 20, c_VID);
    chk_px("f1_row7",  0, c_VB + 23, 20, c_BG);
    chk_px("f1_below", 0, c_VB + 24, 20, c_VID);
    chk_px("f1_row3",  0, c_VB + 19, 19, c_FG);
    chk_px("f1_row3",  0, c_VB + 19, 25, c_FG);
    chk_px("f1_row3",  0, c_VB + 19, 34, c_BG);
    chk_px("f1_row3",  0, c_VB + 19, 36, c_FG);
    chk_px("f1_row3",  0, c_VB + 19, 37, c_FG);
    check_eq("sync_active", {28'h0, cap_s[c_VB + 16][10]},        32'h0);
    check_eq("sync_hs",     {28'h0, cap_s[c_VB + 16][width + 3]}, 32'b1010);
    check_eq("sync_vs",     {28'h0, cap_s[0][5]},                 32'b0101);
    check_eq("sync_vs_hs",  {28'h0, cap_s[0][width + 3]},         32'b1111);
    chk_px("s1", 1, c_VB + 17, 21, c_BG);
    chk_px("s1", 1, c_VB + 17, 22, c_FG);
    chk_px("s1", 1, c_VB + 17, 25, c_FG);
    chk_px("s1", 1, c_VB + 17, 26, c_BG);
    chk_px("s1", 1, c_VB + 17, 39, c_FG);
    chk_px("s1", 1, c_VB + 17, 79, c_BG);
    chk_px("s1", 1, c_VB + 17, 80, c_VID);
    chk_px("s1", 1, c_VB + 17, 20, c_BG);
    chk_px("s1", 1, c_VB + 18, 20, c_FG);
    chk_px("s1", 1, c_VB + 31, 20, c_BG);
    chk_px("s1", 1, c_VB + 32, 20, c_VID);
    chk_px("nobg", 2, c_VB + 16, 16, c_VID);
    chk_px("nobg", 2, c_VB + 16, 19, c_FG);
    chk_px("nobg", 2, c_VB + 23, 20, c_VID);
    chk_px("offscreen", 3, c_VB + 16, 20, c_VID);

    // frame 2: new snapshot shows 0000
    frame(0, c_LINES);
    chk_px("f2_zero", 0, c_VB + 16, 18, c_FG);
    chk_px("f2_zero", 0, c_VB + 16, 26, c_FG);
    chk_px("f2_zero", 0, c_VB + 16, 40, c_BG);
    chk_px("f2_zero", 0, c_VB + 16, 41, c_BG);
    chk_px("f2_zero", 0, c_VB + 19, 16, c_BG);
    chk_px("f2_zero", 0, c_VB + 19, 17, c_FG);
    dbg = 16'h1A2F;

    // frame 3: pixel_ce one clock in four, image must match frame 1
    ce_div = 4;
    frame(0, c_LINES);
    check_row0_1a2f("f3_ce4", 0, c_VB + 16);
    chk_px("f3_ce4_s1", 1, c_VB + 17, 22, c_FG);
    ce_div = 1;

    // frame 4: 640-wide lines, box at X0=630 is clipped at the line end
    width = 640;
    frame(0, c_VB + 20);
    chk_px("clip", 3, c_VB + 16, 629, c_VID);
    chk_px("clip", 3, c_VB + 16, 632, c_BG);
    chk_px("clip", 3, c_VB + 16, 633, c_FG);
    chk_px("clip", 3, c_VB + 16, 634, c_FG);
    chk_px("clip", 3, c_VB + 16, 638, c_BG);
    chk_px("clip", 3, c_VB + 18, 639, c_FG);
    for (int px = 0; px < 4; px++) chk_px("clip_next", 3, c_VB + 17, px, c_VID);
    chk_px("wide", 0, c_VB + 16, 19, c_FG);
    chk_px("wide", 0, c_VB + 16, 100, c_VID);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
